// File: rtl/serial_pkg.sv
// Shared constants and FSM state type for the serial link (scheduler and receiver).
// ST_GAP exists only when SERIAL_SCHED_GAP_EN is defined.
package serial_pkg;

    localparam logic [5:0] SOF_SEQ      = 6'b011010;
    localparam int         SOF_LEN      = 6;
    localparam int         FRAME_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOF  = 2'd1,
        ST_DATA = 2'd2
`ifdef SERIAL_SCHED_GAP_EN
        , ST_GAP = 2'd3
`endif
    } sched_state_t;

endpackage

// File: rtl/serial_frame_scheduler_if.sv
// Requester handshake plus serial line outputs of serial_frame_scheduler.
// master = requester/line consumer side, slave = the scheduler itself.
interface serial_frame_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = serial_pkg::FRAME_DATA_W
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      serData;
    logic                      busy;
    logic [IDX_W-1:0]          grant_id;
    logic                      frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, serData, busy, grant_id, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, serData, busy, grant_id, frame_done
    );
endinterface

// File: rtl/serial_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, with wrap.
// Produces a one-hot grant and its index; nothing is granted while en is low.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_REQ);

    // NOTE: every signal written here gets a default before the loop, so no latch is inferred.
    always_comb begin
        logic             found;
        logic [IDX_W:0]   slot;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit holds ptr+k before folding it back into 0..NUM_REQ-1.
            slot = {1'b0, ptr} + (IDX_W+1)'(k);
            if (slot >= LIMIT) begin
                slot = slot - LIMIT;
            end
            if (en && !found && req[slot[IDX_W-1:0]]) begin
                found                   = 1'b1;
                gnt[slot[IDX_W-1:0]]    = 1'b1;
                gnt_idx                 = slot[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Round-robin transmit scheduler: SOF sequence then MSB-first word on serData.
// Define SERIAL_SCHED_GAP_EN to insert one idle GAP cycle after every frame.
module serial_frame_scheduler
    import serial_pkg::*;
#(
    parameter int                 NUM_REQ = 4,
    parameter int                 DATA_W  = FRAME_DATA_W,
    parameter logic [SOF_LEN-1:0] SOF     = SOF_SEQ
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_frame_scheduler_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0]       SOF_LAST  = 3'(SOF_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    sched_state_t        state_q, state_d;
    logic [2:0]          sof_cnt_q, sof_cnt_d;
    logic [CNT_W-1:0]    data_cnt_q, data_cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                ser_q, ser_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic                arb_slot;
    logic                arb_en;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                grant;
    logic [DATA_W-1:0]   word;

`ifdef SERIAL_SCHED_GAP_EN
    assign arb_slot = (state_q == ST_IDLE) || (state_q == ST_GAP);
`else
    assign arb_slot = (state_q == ST_IDLE) ||
                      ((state_q == ST_DATA) && (data_cnt_q == DATA_LAST));
`endif
    // Masking with rst keeps req_ready low for the whole reset window.
    assign arb_en = arb_slot && !rst;
    assign grant  = |gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        sof_cnt_d  = sof_cnt_q;
        data_cnt_d = data_cnt_q;
        shreg_d    = shreg_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        word       = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                word = word | bus.req_data[i*DATA_W +: DATA_W];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_SOF;
                    sof_cnt_d = '0;
                end
            end
            ST_SOF: begin
                if (sof_cnt_q == SOF_LAST) begin
                    state_d    = ST_DATA;
                    data_cnt_d = '0;
                end else begin
                    sof_cnt_d = sof_cnt_q + 3'd1;
                end
            end
            ST_DATA: begin
                shreg_d = shreg_q << 1;
                if (data_cnt_q == DATA_LAST) begin
`ifdef SERIAL_SCHED_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d   = grant ? ST_SOF : ST_IDLE;
                    sof_cnt_d = '0;
`endif
                end else begin
                    data_cnt_d = data_cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_SCHED_GAP_EN
            ST_GAP: begin
                state_d   = grant ? ST_SOF : ST_IDLE;
                sof_cnt_d = '0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            shreg_d    = word;
            grant_id_d = gnt_idx;
            rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        // Line outputs are decoded from the next state so they can be driven straight from flops.
        ser_d        = 1'b1;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        if (state_d == ST_SOF) begin
            ser_d  = SOF[SOF_LAST - sof_cnt_d];
            busy_d = 1'b1;
        end else if (state_d == ST_DATA) begin
            ser_d        = shreg_d[DATA_W-1];
            busy_d       = 1'b1;
            frame_done_d = (data_cnt_d == DATA_LAST);
        end
    end

    // NOTE: sequential state is updated with <= only; the comb block above uses = for its temporaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sof_cnt_q    <= '0;
            data_cnt_q   <= '0;
            // NOTE: the shift register is cleared as well, so an aborted word never resurfaces.
            shreg_q      <= '0;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            ser_q        <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sof_cnt_q    <= sof_cnt_d;
            data_cnt_q   <= data_cnt_d;
            shreg_q      <= shreg_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            ser_q        <= ser_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.serData    = ser_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/serial_frame_scheduler.md
# serial_frame_scheduler

Transmit-side scheduler for the serial link. It shares one `serData` line among `NUM_REQ` word sources using round-robin arbitration. For each granted 32-bit word it emits the start-of-frame sequence 011010 followed by the word MSB-first. Its `serData` output drives `serial_communication` directly, so it is the sequencer feeding that receiver's datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..16.
- `DATA_W`, default 32: payload bits per frame; must equal the receiver's payload length.
- `SOF`, default 6'b011010: start sequence, sent bit 5 first.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a word pending.
- `req_data`  in  NUM_REQ*DATA_W  word of requester i at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  one-hot acceptance strobe.
- `serData`  out  1  serial line; idles at 1.
- `busy`  out  1  high while SOF or payload bits are on the line.
- `grant_id`  out  $clog2(NUM_REQ)  index of the requester whose frame is on the line; holds its last value when idle.
- `frame_done`  out  1  one-cycle pulse during the last payload bit.

## Operation
- FSM states: `IDLE`, `SOF`, `DATA`, plus `GAP` when the macro is set. A 3-bit SOF counter and a $clog2(DATA_W)-bit data counter run inside the FSM.
- Arbitration is enabled in these cycles:
  - `IDLE`;
  - the last `DATA` cycle (no-gap build);
  - `GAP` (gap build).
- Arbitration rule: scan from `rr_ptr` upward with wrap-around, and grant the first i with `req_valid[i]`=1.
- In that same cycle, `req_ready[i]`=1 (combinational). The word is captured into the shift register on the clock edge; `rr_ptr` becomes (i+1) mod NUM_REQ and `grant_id` becomes i.
- A requester keeps `req_valid` and `req_data` stable until it sees `req_ready`. It may drop `req_valid` before being granted; no frame is then sent for it.
- `SOF`: 6 cycles, `serData`=SOF[5]..SOF[0] (0,1,1,0,1,0).
- `DATA`: DATA_W cycles, `serData`=word[DATA_W-1]..word[0]. `frame_done`=1 on the word[0] cycle.
- End of `DATA`, no-gap build: go to `SOF` if a grant occurred, otherwise `IDLE`.
- `IDLE` and `GAP`: `serData`=1, `busy`=0.
- `serData`, `busy`, `grant_id` and `frame_done` come only from flops, so the line is glitch-free.

## Timing
- Reset values: `serData`=1, `busy`=0, `grant_id`=0, `frame_done`=0, `req_ready`=0, `rr_ptr`=0, state `IDLE`.
- Grant in cycle T:
  - SOF bit 5 is on the line in T+1;
  - payload MSB in T+7;
  - payload LSB in T+6+DATA_W (T+38 at default), where `frame_done`=1.
- Back-to-back, no-gap build: the next SOF bit 5 appears in T+39. There is no idle cycle between frames.
- `rst` asserted mid-frame: at the next edge the frame is aborted, the captured word is lost, and all outputs take their reset values. `req_ready`=0 in any cycle where `rst`=1.
- All NUM_REQ valid continuously: grants follow 0,1,2,3,0,… One frame per requester per NUM_REQ frames, so no requester starves.
- A `req_valid` rising during a frame waits for the next arbitration cycle. Only that cycle samples requests.

## Configuration
- `SERIAL_SCHED_GAP_EN` defined:
  - after the last payload bit the FSM enters `GAP` for exactly 1 cycle, with `serData`=1;
  - arbitration moves from the last `DATA` cycle to `GAP`;
  - back-to-back frame period becomes 6+DATA_W+1 cycles, and the next SOF starts at T+40.
- Not defined: `GAP` is not compiled, frames may be back-to-back, and the period is 6+DATA_W cycles.

## Structure
- Shared package `serial_pkg`:
  - `SOF_SEQ` (6'b011010), `SOF_LEN` (6), `FRAME_DATA_W` (32);
  - the `sched_state_t` enum.
- The receiver uses the same constants from `serial_pkg`.
- One sub-module, `rr_arbiter`:
  - inputs: `req` (NUM_REQ), `ptr`, `en`;
  - outputs: one-hot `gnt` and `gnt_idx`;
  - purely combinational.
- The FSM, counters, shift register and `rr_ptr` stay in `serial_frame_scheduler`.

## Test plan
- Single frame: only requester 2 valid with 32'hA5A5_0F0F → `req_ready[2]` pulses once; `serData` = 011010 then 10100101101001010000111100001111; `frame_done` on the last bit; `grant_id`=2; loop-back into `serial_communication` raises `outValid` after the SOF.
- Round-robin: all 4 requesters continuously valid with distinct words → grant order 0,1,2,3,0. Frames are contiguous, with a 38-cycle period (no-gap build).
- Gap build (`SERIAL_SCHED_GAP_EN`): same stimulus → exactly one `serData`=1 cycle between frames, 39-cycle period.
- Reset mid-frame: assert `rst` for 2 cycles during payload bit 9 → `serData`=1 and `busy`=0 from the next edge. After release the pending requester is re-granted from `rr_ptr`=0 and a full frame follows.
- Withdrawn request: requester 1 raises `req_valid` during a frame, then drops it before the arbitration cycle → no grant to 1 and no `req_ready[1]`; the line returns to `IDLE` (`serData`=1).
- Pointer wrap: only requester 3 valid, then only requester 0 → requester 0 is granted next and `rr_ptr` wraps 3→0→1.
